// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe scheduler and the collision/render blocks that
// consume its slot outputs.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_LOST = 3'b100
  } state_e;

  localparam int         NUM_SLOTS       = 3;
  localparam int         GAP_MIN         = 40;
  localparam int         GAP_SPAN        = 400;
  localparam logic [8:0] LFSR_SEED       = 9'h1A5;
  localparam logic [8:0] LFSR_TAPS       = 9'h110;  // bits 9 and 5 (1-based)
  localparam int         SPAWN_X_DEFAULT = 640;

  // Folds the 9-bit LFSR value into GAP_SPAN values starting at GAP_MIN.
  function automatic logic [9:0] gap_from_lfsr(input logic [8:0] g);
    logic [9:0] v;
    v = {1'b0, g};
    if (v >= 10'(GAP_SPAN)) v = v - 10'd256;
    return v + 10'(GAP_MIN);
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 9-bit Fibonacci LFSR supplying pseudo-random gap heights; never leaves the
// non-zero cycle because it is seeded non-zero.
module pipe_lfsr
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [8:0] lfsr
);

  logic [8:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[7:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe scheduler: spawns pipes into three slots, scrolls them left on each move
// tick, retires them at X==0 and scores pipes passing the bird column.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int TICK_DIV     = 500000,
  parameter int SPAWN_PERIOD = 300,
  parameter int SPAWN_X      = SPAWN_X_DEFAULT
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Start,
  input  logic       Lost,
  input  logic [9:0] BirdX,
  output logic [9:0] PipeX0,
  output logic [9:0] PipeX1,
  output logic [9:0] PipeX2,
  output logic [9:0] GapY0,
  output logic [9:0] GapY1,
  output logic [9:0] GapY2,
  output logic [2:0] Active,
  output logic [7:0] Score,
  output logic       ScoreInc,
  output logic       Overflow
);

  localparam int              PW       = $clog2(TICK_DIV);
  localparam int              SW       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]   SPN_LAST = SW'(SPAWN_PERIOD - 1);
  localparam logic [9:0]      X_SPAWN  = 10'(SPAWN_X);

  state_e                     state_q, state_d;
  logic [PW-1:0]              pre_q, pre_d;
  logic [SW-1:0]              spn_q, spn_d;
  logic [NUM_SLOTS-1:0][9:0]  px_q, px_d;
  logic [NUM_SLOTS-1:0][9:0]  gy_q, gy_d;
  logic [NUM_SLOTS-1:0]       act_q, act_d;
  logic [7:0]                 score_q, score_d;
  logic                       inc_q, inc_d;
  logic                       ovf_q, ovf_d;

  logic [8:0]                 lfsr;
  logic [9:0]                 gap_new;
  logic [NUM_SLOTS-1:0]       hit;
  logic [NUM_SLOTS-1:0]       free_slots;
  logic [NUM_SLOTS-1:0]       spawn_sel;
  logic                       tick;
  logic                       spawn;

  pipe_lfsr u_lfsr (
    .clk   (Clk),
    .rst_n (ResetN),
    .en    (1'b1),
    .lfsr  (lfsr)
  );

  assign gap_new = gap_from_lfsr(lfsr);

  // A live pipe sitting on the bird column scores as it steps past it.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign hit[gi] = act_q[gi] && (BirdX != 10'd0) && (px_q[gi] == BirdX);
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    spn_d      = spn_q;
    px_d       = px_q;
    gy_d       = gy_q;
    act_d      = act_q;
    score_d    = score_q;
    inc_d      = 1'b0;
    ovf_d      = ovf_q;
    tick       = 1'b0;
    spawn      = 1'b0;
    free_slots = '0;
    spawn_sel  = '0;

    case (state_q)
      ST_IDLE: begin
        pre_d   = '0;
        spn_d   = '0;
        px_d    = '0;
        gy_d    = '0;
        act_d   = '0;
        score_d = '0;
        ovf_d   = 1'b0;
        if (Start) begin
          state_d  = ST_RUN;
          act_d[0] = 1'b1;
          px_d[0]  = X_SPAWN;
          gy_d[0]  = gap_new;
        end
      end

      ST_RUN: begin
        if (Lost) begin
          state_d = ST_LOST;
        end else begin
          tick  = (pre_q == PRE_LAST);
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (act_q[i]) begin
                if (px_q[i] == 10'd0) act_d[i] = 1'b0;
                else                  px_d[i]  = px_q[i] - 10'd1;
              end
            end
            spawn = (spn_q == SPN_LAST);
            spn_d = spawn ? '0 : spn_q + 1'b1;
            if ((|hit) && (score_q != 8'hFF)) begin
              score_d = score_q + 8'd1;
              inc_d   = 1'b1;
            end
          end
          // Slots retired on this edge are already free for this edge's spawn.
          free_slots = ~act_d;
          spawn_sel  = free_slots & (~free_slots + 1'b1);
          if (spawn) begin
            if (free_slots == '0) begin
              ovf_d = 1'b1;
            end else begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (spawn_sel[i]) begin
                  act_d[i] = 1'b1;
                  px_d[i]  = X_SPAWN;
                  gy_d[i]  = gap_new;
                end
              end
            end
          end
        end
      end

      ST_LOST: begin
        if (Start) begin
          state_d = ST_IDLE;
          pre_d   = '0;
          spn_d   = '0;
          px_d    = '0;
          gy_d    = '0;
          act_d   = '0;
          score_d = '0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      spn_q   <= '0;
      px_q    <= '0;
      gy_q    <= '0;
      act_q   <= '0;
      score_q <= '0;
      inc_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      spn_q   <= spn_d;
      px_q    <= px_d;
      gy_q    <= gy_d;
      act_q   <= act_d;
      score_q <= score_d;
      inc_q   <= inc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign PipeX0   = px_q[0];
  assign PipeX1   = px_q[1];
  assign PipeX2   = px_q[2];
  assign GapY0    = gy_q[0];
  assign GapY1    = gy_q[1];
  assign GapY2    = gy_q[2];
  assign Active   = act_q;
  assign Score    = score_q;
  assign ScoreInc = inc_q;
  assign Overflow = ovf_q;

endmodule
